// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - multiply/divide op codes and issue-queue entry type shared by decoder, queue and unit
package md_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd3;
  localparam logic [3:0] OP_DIV   = 4'd4;
  localparam logic [3:0] OP_MULTU = 4'd8;
  localparam logic [3:0] OP_DIVU  = 4'd9;
  localparam logic [3:0] OP_MTHI  = 4'd10;
  localparam logic [3:0] OP_MTLO  = 4'd11;
  localparam logic [3:0] OP_MFHI  = 4'd12;
  localparam logic [3:0] OP_MFLO  = 4'd13;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  dst;
  } md_entry_t;

  function automatic logic is_md_op(input logic [3:0] op);
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
      OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic is_mf(input logic [3:0] op);
    return (op == OP_MFHI) || (op == OP_MFLO);
  endfunction

endpackage

// File: rtl/md_issue_if.sv
// rtl/md_issue_if.sv - op push handshake from the D stage and mfhi/mflo result return
interface md_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_rs;
  logic [31:0] in_rt;
  logic [4:0]  in_dst;
  logic        res_valid;
  logic [31:0] res_data;
  logic [4:0]  res_dst;

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_dst,
    input  in_ready, res_valid, res_data, res_dst
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_dst,
    output in_ready, res_valid, res_data, res_dst
  );
endinterface

// File: rtl/md_fifo2.sv
// rtl/md_fifo2.sv - two-entry queue of md ops with count and head view
module md_fifo2
  import md_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       push,
  input  md_entry_t  push_data,
  input  logic       pop,
  output logic [1:0] count,
  output md_entry_t  head
);

  md_entry_t mem [2];
  logic      wr_ptr;
  logic      rd_ptr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/md_issue.sv
// rtl/md_issue.sv - in-order issue of queued multiply/divide ops and hi/lo reads
module md_issue
  import md_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  md_issue_if.slave   up,
  output logic [3:0]  md_aluop,
  output logic [31:0] md_op1,
  output logic [31:0] md_op2,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  input  logic        md_busy
);

  logic [1:0] count;
  md_entry_t  head;
  md_entry_t  in_entry;
  logic       store;
  logic       issue;
  logic       issue_mf;

  assign up.in_ready = (count != 2'(DEPTH));
  assign in_entry    = '{op: up.in_op, rs: up.in_rs, rt: up.in_rt, dst: up.in_dst};

  // Unknown op codes complete the handshake but never occupy a slot.
  assign store    = up.in_valid && up.in_ready && !flush && is_md_op(up.in_op);
  assign issue    = (count != 2'd0) && !md_busy && !flush;
  assign issue_mf = issue && is_mf(head.op);

  md_fifo2 u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clr       (flush),
    .push      (store),
    .push_data (in_entry),
    .pop       (issue),
    .count     (count),
    .head      (head)
  );

  always_comb begin
    md_aluop = OP_NOP;
    md_op1   = 32'd0;
    md_op2   = 32'd0;
    if (issue && !issue_mf) begin
      md_aluop = head.op;
      md_op1   = head.rs;
      md_op2   = head.rt;
    end
  end

  // hi/lo are sampled in the issue cycle; the unit updates them on that same edge at the earliest.
  always_ff @(posedge clk) begin
    if (reset) begin
      up.res_valid <= 1'b0;
      up.res_data  <= 32'd0;
      up.res_dst   <= 5'd0;
    end else begin
      up.res_valid <= issue_mf;
      if (issue_mf) begin
        up.res_data <= (head.op == OP_MFHI) ? md_hi : md_lo;
        up.res_dst  <= head.dst;
      end
    end
  end

endmodule

// File: doc/md_issue.md
MD_ISSUE -- requirements
Module: md_issue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, meaning the number of queue entries (fixed at 2 for this revision).
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 flush  input  1  drop all queued ops and any pending result.
REQ-005 in_valid  input  1  the D stage presents an op.
REQ-006 in_ready  output  1  the queue can accept an op this cycle.
REQ-007 in_op  input  4  op code: 3 mult, 8 multu, 4 div, 9 divu, 10 mthi, 11 mtlo, 12 mfhi, 13 mflo.
REQ-008 in_rs  input  32  rs operand value.
REQ-009 in_rt  input  32  rt operand value.
REQ-010 in_dst  input  5  destination GPR index; used only by mfhi and mflo.
REQ-011 md_aluop  output  4  op code driven to the multiply/divide unit; 0 means no operation.
REQ-012 md_op1  output  32  operand1 driven to the multiply/divide unit.
REQ-013 md_op2  output  32  operand2 driven to the multiply/divide unit.
REQ-014 md_hi  input  32  hi value returned by the multiply/divide unit.
REQ-015 md_lo  input  32  lo value returned by the multiply/divide unit.
REQ-016 md_busy  input  1  the multiply/divide unit is busy.
REQ-017 res_valid  output  1  single-cycle pulse: an mfhi or mflo result is available.
REQ-018 res_data  output  32  the hi or lo value read.
REQ-019 res_dst  output  5  destination register for res_data.

Function
REQ-020 The block SHALL hold a FIFO of {op, rs, rt, dst} entries (73 bits each) with 2-bit count 0..2.
REQ-021 A push SHALL occur when in_valid && in_ready; in_ready SHALL be (count != 2), registered-state only, with no same-cycle pop bypass.
REQ-022 A push with an op code outside REQ-007 SHALL be accepted and discarded, leaving count unchanged.
REQ-023 Head issue condition: count != 0 && !md_busy && !flush.
REQ-024 Head mult/multu/div/divu/mthi/mtlo: when the issue condition holds, drive md_aluop = head op, md_op1 = rs, md_op2 = rt for exactly that cycle, and pop.
REQ-025 Head mfhi/mflo: when the issue condition holds, sample md_hi or md_lo, pop, and in the next cycle assert res_valid = 1 with res_data = the sampled value and res_dst = the entry's dst.
REQ-026 When not issuing, md_aluop, md_op1 and md_op2 SHALL be 0.
REQ-027 At most one pop SHALL occur per cycle; a simultaneous push and pop at count 1 SHALL leave count at 1.
REQ-028 When md_busy = 1, the head SHALL wait; this ordering guarantees mfhi/mflo never read a stale value after a mult/div.
REQ-029 mthi followed by mfhi SHALL return the mthi value, since the write lands on the issue edge and the mfhi issues no earlier than the next cycle.
REQ-030 flush SHALL clear count and pointers and suppress res_valid in the following cycle.
REQ-031 An op already issued before a flush SHALL NOT be cancelled.
REQ-032 A push in the flush cycle SHALL be dropped.
REQ-033 Pointers SHALL wrap modulo 2.

Reset
REQ-034 On reset: count = 0, pointers = 0, res_valid = 0, res_data = 0, res_dst = 0, md_aluop = 0, md_op1 = 0, md_op2 = 0.
REQ-035 On reset: in_ready SHALL be 1 in the first cycle after reset.
REQ-036 Reset SHALL take priority over flush and push.

Structure
REQ-037 The op code constants (REQ-007) SHALL be defined in a shared package md_pkg, also used by the decoder and the multiply/divide unit.
REQ-038 The FIFO storage SHALL be a sub-module md_fifo2 (push/pop/count/head); issue and result logic SHALL stay in md_issue.

Verification
REQ-039 Scenario: push mult rs=7 rt=-3 with md_busy=0 -> next cycle md_aluop=3, md_op1=7, md_op2=0xFFFFFFFD for one cycle; count returns to 0.
REQ-040 Scenario: push mult, then mflo; md_busy high 5 cycles -> mflo stays queued, issues in the first cycle md_busy=0, res_valid pulses next cycle with res_data=md_lo (-21) and the correct res_dst.
REQ-041 Scenario: push 3 ops back-to-back with md_busy=1 -> in_ready=0 after 2 pushes, third op held by the producer, none lost.
REQ-042 Scenario: mthi rs=0x1234, then mfhi dst=5 -> res_data=0x1234, res_dst=5.
REQ-043 Scenario: queue holds 2 ops and flush=1 -> count=0, no md_aluop, no res_valid; a pending mf result is also suppressed.
REQ-044 Scenario: reset asserted mid-queue with an mfhi pending -> all outputs 0 on the next cycle, in_ready=1.
